// File: rtl/hub75_pkg.sv
// Shared types and geometry for the HUB75 scan scheduler.
// Slice/row widths and the scheduler state encoding.
package hub75_pkg;

  localparam int ROTATIONAL_RES = 180;
  localparam int SCAN_RATE      = 32;
  localparam int SLICE_W        = $clog2(ROTATIONAL_RES);
  localparam int ROW_W          = $clog2(SCAN_RATE);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_FB,
    PRESENT
  } sched_state_t;

endpackage

// File: rtl/hub75_scan_scheduler_if.sv
// Frame-buffer read bus plus payload stream to hub75_output.
// master = scheduler side, slave = frame buffer / output side.
interface hub75_scan_scheduler_if #(
  parameter int DATA_W = 1152
) ();
  import hub75_pkg::*;

  logic               fb_req_out;
  logic [SLICE_W-1:0] fb_slice_out;
  logic [ROW_W-1:0]   fb_row_out;
  logic               fb_valid_in;
  logic [DATA_W-1:0]  fb_data_in;
  logic               tvalid_out;
  logic               tready_in;
  logic [DATA_W-1:0]  data_out;

  modport master (
    output fb_req_out, fb_slice_out, fb_row_out,
    output tvalid_out, data_out,
    input  fb_valid_in, fb_data_in, tready_in
  );

  modport slave (
    input  fb_req_out, fb_slice_out, fb_row_out,
    input  tvalid_out, data_out,
    output fb_valid_in, fb_data_in, tready_in
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Ports: clk_in, rst_in, inc_in in; cnt_out holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc_in,
  output logic [W-1:0] cnt_out
);

  always_ff @(posedge clk_in) begin
    if (!rst_in)
      cnt_out <= '0;
    else if (inc_in && (cnt_out != '1))
      cnt_out <= cnt_out + 1'b1;
  end

endmodule

// File: rtl/hub75_scan_scheduler.sv
// Row-scan sequencer: per slice, fetch and present rows 0..SCAN_RATE-1.
// Ports: clk/rst/enable, slice strobe+idx, bus (fb + stream), addr, done, overrun.
module hub75_scan_scheduler
  import hub75_pkg::*;
#(
  parameter int DATA_W = 1152
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic                   slice_valid_in,
  input  logic [SLICE_W-1:0]     slice_idx_in,
  hub75_scan_scheduler_if.master bus,
  output logic [ROW_W-1:0]       hub75_addr_out,
  output logic                   sweep_done_out,
  output logic [15:0]            overrun_cnt_out
);

  sched_state_t       state_q, state_d;
  logic [SLICE_W-1:0] slice_q, pend_idx_q;
  logic [ROW_W-1:0]   row_q, addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               pend_q, done_q, done_d;

  logic               xfer, last, busy_strobe;
  logic               take_new, overrun_inc;
  logic [SLICE_W-1:0] next_slice;

  assign xfer        = (state_q == PRESENT) && bus.tready_in;
  assign last        = (row_q == ROW_W'(SCAN_RATE - 1));
  assign busy_strobe = slice_valid_in && (state_q != IDLE);
  // a strobe landing on the transfer edge is consumed right away
  assign take_new    = xfer && enable_in && (pend_q || slice_valid_in);
  assign overrun_inc = busy_strobe && !(xfer && last);
  assign next_slice  = slice_valid_in ? slice_idx_in : pend_idx_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:
        if (slice_valid_in && enable_in)
          state_d = FETCH;
      FETCH:
        state_d = WAIT_FB;
      WAIT_FB:
        if (bus.fb_valid_in)
          state_d = PRESENT;
      PRESENT:
        if (xfer) begin
          done_d = last && !pend_q;
          if (take_new || (enable_in && !last))
            state_d = FETCH;
          else
            state_d = IDLE;
        end
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      slice_q    <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if ((state_q == IDLE) && slice_valid_in && enable_in) begin
        slice_q <= slice_idx_in;
        row_q   <= '0;
      end
      if ((state_q == WAIT_FB) && bus.fb_valid_in)
        data_q <= bus.fb_data_in;
      if (xfer) begin
        addr_q <= row_q;
        if (take_new) begin
          slice_q <= next_slice;
          row_q   <= '0;
        end else if (enable_in && !last) begin
          row_q <= row_q + 1'b1;
        end
      end
      if (xfer) begin
        pend_q <= 1'b0;
      end else if (busy_strobe) begin
        pend_q     <= 1'b1;
        pend_idx_q <= slice_idx_in;
      end
    end
  end

  sat_counter #(.W(16)) u_overrun (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (overrun_inc),
    .cnt_out (overrun_cnt_out)
  );

  assign bus.fb_req_out   = (state_q == FETCH);
  assign bus.fb_slice_out = slice_q;
  assign bus.fb_row_out   = row_q;
  assign bus.tvalid_out   = (state_q == PRESENT);
  assign bus.data_out     = data_q;
  assign hub75_addr_out   = addr_q;
  assign sweep_done_out   = done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Scoreboard bench for hub75_scan_scheduler.
// Stimulus queues expected transfers; a negedge monitor pops and checks.
module tb_hub75_scan_scheduler;
  import hub75_pkg::*;

  localparam int DW = 1152;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               sv;
  logic [SLICE_W-1:0] idx;
  logic [ROW_W-1:0]   addr;
  logic               done;
  logic [15:0]        ovr;

  hub75_scan_scheduler_if #(.DATA_W(DW)) bus ();

  hub75_scan_scheduler #(.DATA_W(DW)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .enable_in       (enable),
    .slice_valid_in  (sv),
    .slice_idx_in    (idx),
    .bus             (bus),
    .hub75_addr_out  (addr),
    .sweep_done_out  (done),
    .overrun_cnt_out (ovr)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int r; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int sweep_cnt = 0;
  int addr_exp = 0;
  bit addr_chk = 0;

  function automatic logic [DW-1:0] pat(int s, int r);
    logic [31:0] w;
    w = {8'hA5, s[7:0], r[7:0], 8'h3C};
    return {(DW/32){w}};
  endfunction

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic chk_data(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got low64 %h expected low64 %h",
               n, a[63:0], e[63:0]);
    end
  endtask

  task automatic push_rows(int s, int r0, int r1);
    for (int r = r0; r <= r1; r++) q.push_back('{s: s, r: r});
  endtask

  task automatic strobe(int s);
    @(posedge clk); #1;
    sv = 1'b1;
    idx = SLICE_W'(s);
    @(posedge clk); #1;
    sv = 1'b0;
  endtask

  task automatic wait_sweeps(int n);
    int i = 0;
    while (sweep_cnt < n && i < 4000) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    chk("sweep_count", sweep_cnt, n);
  endtask

  task automatic wait_tvalid();
    int i = 0;
    while (!bus.tvalid_out && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("tvalid_wait", bus.tvalid_out, 1);
  endtask

  // frame buffer model: data two cycles after each request
  int fb_t = 0;
  logic [DW-1:0] fb_pat;
  initial begin
    bus.fb_valid_in = 1'b0;
    bus.fb_data_in  = '0;
    forever begin
      @(negedge clk);
      bus.fb_valid_in = 1'b0;
      if (fb_t > 0) begin
        fb_t--;
        if (fb_t == 0) begin
          bus.fb_valid_in = 1'b1;
          bus.fb_data_in  = fb_pat;
        end
      end
      if (bus.fb_req_out) begin
        fb_t = 2;
        fb_pat = pat(int'(bus.fb_slice_out), int'(bus.fb_row_out));
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (addr_chk) begin
        chk("hub75_addr", addr, addr_exp);
        addr_chk = 0;
      end
      if (bus.tvalid_out && bus.tready_in) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: slice %0d row %0d with empty queue",
                   bus.fb_slice_out, bus.fb_row_out);
        end else begin
          e = q.pop_front();
          chk("xfer_slice", bus.fb_slice_out, e.s);
          chk("xfer_row", bus.fb_row_out, e.r);
          chk_data("xfer_data", bus.data_out, pat(e.s, e.r));
          addr_exp = e.r;
          addr_chk = 1;
        end
      end
      if (done) sweep_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i;
    rst_n = 1'b0;
    enable = 1'b0;
    sv = 1'b0;
    idx = '0;
    bus.tready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus.fb_req_out, 0);
    chk("rst_tvalid", bus.tvalid_out, 0);
    chk("rst_addr", addr, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr, 0);
    chk_data("rst_data", bus.data_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    strobe(5);
    chk("ignored_when_disabled", bus.fb_req_out, 0);
    enable = 1'b1;

    // full sweep of slice 5
    push_rows(5, 0, 31);
    strobe(5);
    @(negedge clk);
    chk("req_latency", bus.fb_req_out, 1);
    chk("req_slice", bus.fb_slice_out, 5);
    wait_sweeps(1);
    chk("ovr_sweep1", ovr, 0);
    chk("addr_last", addr, 31);

    // backpressure in PRESENT
    bus.tready_in = 1'b0;
    push_rows(9, 0, 31);
    strobe(9);
    wait_tvalid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_tvalid", bus.tvalid_out, 1);
      chk("hold_noreq", bus.fb_req_out, 0);
      chk_data("hold_data", bus.data_out, pat(9, 0));
    end
    @(posedge clk); #1;
    bus.tready_in = 1'b1;
    wait_sweeps(2);
    chk("ovr_sweep2", ovr, 0);

    // abort at row 12 by slice 7
    push_rows(3, 0, 12);
    push_rows(7, 0, 31);
    strobe(3);
    i = 0;
    while (!(bus.fb_req_out && bus.fb_row_out == 12) && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("row12_seen", bus.fb_row_out, 12);
    @(posedge clk); #1;
    sv = 1'b1;
    idx = 7;
    @(posedge clk); #1;
    sv = 1'b0;
    wait_sweeps(3);
    chk("ovr_abort", ovr, 1);

    // strobe on the row 31 transfer edge
    push_rows(11, 0, 31);
    push_rows(13, 0, 31);
    strobe(11);
    i = 0;
    while (!(bus.tvalid_out && bus.fb_row_out == 31) && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("row31_seen", bus.fb_row_out, 31);
    sv = 1'b1;
    idx = 13;
    @(posedge clk); #1;
    sv = 1'b0;
    wait_sweeps(5);
    chk("ovr_coincident", ovr, 1);

    // reset during WAIT_FB, then stray fb_valid
    strobe(2);
    @(negedge clk);
    chk("req_before_rst", bus.fb_req_out, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("wrst_req", bus.fb_req_out, 0);
    chk("wrst_tvalid", bus.tvalid_out, 0);
    chk("wrst_slice", bus.fb_slice_out, 0);
    chk("wrst_row", bus.fb_row_out, 0);
    chk("wrst_addr", addr, 0);
    chk("wrst_done", done, 0);
    chk("wrst_ovr", ovr, 0);
    chk_data("wrst_data", bus.data_out, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stray_tvalid", bus.tvalid_out, 0);
      chk("stray_req", bus.fb_req_out, 0);
    end

    // overrun saturation
    bus.tready_in = 1'b0;
    push_rows(1, 0, 0);
    push_rows(4, 0, 31);
    strobe(1);
    wait_tvalid();
    @(posedge clk); #1;
    sv = 1'b1;
    idx = 4;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("ovr_fffe", ovr, 16'hFFFE);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovr_sat", ovr, 16'hFFFF);
    @(posedge clk); #1;
    sv = 1'b0;
    bus.tready_in = 1'b1;
    wait_sweeps(6);
    chk("ovr_hold", ovr, 16'hFFFF);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
